// File: rtl/vjtag_dr_ctrl_if.sv
// User-side handshake bundle of vjtag_dr_ctrl: write words out to user logic,
// read words in from user logic. The controller takes the master modport.
interface vjtag_dr_ctrl_if #(
    parameter int DW = 32
);
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/vjtag_dr_ctrl.sv
// Virtual-JTAG DR controller: turns host DR scans into user write words,
// buffers one user read word for the host, and reports sticky error status.
module vjtag_dr_ctrl #(
    parameter int DW = 32
) (
    input  logic tck,
    input  logic rst,
    input  logic tdi,
    output logic tdo,
    input  logic ir_in,
    output logic ir_out,
    input  logic virtual_state_cdr,
    input  logic virtual_state_sdr,
    input  logic virtual_state_udr,
    input  logic virtual_state_cir,
    input  logic virtual_state_uir,
    vjtag_dr_ctrl_if.master bus
);
    localparam int CW = $clog2(DW + 2);
    localparam logic [CW-1:0] CNT_DW  = CW'(DW);
    localparam logic [CW-1:0] CNT_MAX = CW'(DW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SH_RD = 2'd1,
        SH_WR = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rd_hold_q, rd_hold_d;
    logic          rd_full_q, rd_full_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          wr_valid_q, wr_valid_d;
    logic          ovf_q, ovf_d;
    logic          short_q, short_d;
    logic          ir_out_q, tdo_q;

    logic abort_s, cap_rd_s, cap_wr_s, shift_s, end_rd_s, end_wr_s;
    logic wr_fire_s, wr_keep_s, cnt_full_s, wr_load_s;
    logic rd_ready_s, rd_fire_s, rd_take_s;

    function automatic logic [DW-1:0] status_word(input logic v, input logic o,
                                                  input logic s, input logic f);
        logic [DW-1:0] w;
        w      = '0;
        w[3:0] = {f, s, o, v};
        return w;
    endfunction

    assign abort_s    = virtual_state_cir | virtual_state_uir;
    assign rd_ready_s = ~rd_full_q & ~rst;

    // Scan sequencing: decide the next state and which scan event fires this cycle.
    always_comb begin
        state_d  = state_q;
        cap_rd_s = 1'b0;
        cap_wr_s = 1'b0;
        shift_s  = 1'b0;
        end_rd_s = 1'b0;
        end_wr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort_s) begin
                    state_d = IDLE;
                end else if (virtual_state_cdr) begin
                    if (ir_in) begin
                        state_d  = SH_WR;
                        cap_wr_s = 1'b1;
                    end else begin
                        state_d  = SH_RD;
                        cap_rd_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SH_RD, SH_WR: begin
                if (abort_s) begin
                    state_d = IDLE;
                end else if (virtual_state_udr) begin
                    state_d  = IDLE;
                    end_rd_s = (state_q == SH_RD);
                    end_wr_s = (state_q == SH_WR);
                end else if (virtual_state_sdr) begin
                    shift_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next-state; the user write handshake is resolved before a UDR load.
    always_comb begin
        wr_fire_s  = wr_valid_q & bus.wr_ready;
        wr_keep_s  = wr_valid_q & ~wr_fire_s;
        cnt_full_s = (cnt_q == CNT_DW);
        wr_load_s  = end_wr_s & cnt_full_s & ~wr_keep_s;
        rd_fire_s  = bus.rd_valid & rd_ready_s;
        rd_take_s  = end_rd_s & (cnt_q >= CNT_DW) & rd_full_q;

        sr_d = cap_rd_s ? (rd_full_q ? rd_hold_q : '0) :
               cap_wr_s ? status_word(wr_valid_q, ovf_q, short_q, rd_full_q) :
               shift_s  ? {tdi, sr_q[DW-1:1]} : sr_q;
        cnt_d = (cap_rd_s | cap_wr_s)          ? '0 :
                (shift_s && cnt_q != CNT_MAX)  ? cnt_q + CW'(1) : cnt_q;

        wr_data_d  = wr_load_s ? sr_q : wr_data_q;
        wr_valid_d = wr_load_s | wr_keep_s;
        ovf_d      = cap_wr_s ? 1'b0 : (end_wr_s & cnt_full_s & wr_keep_s) ? 1'b1 : ovf_q;
        short_d    = cap_wr_s ? 1'b0 : (end_wr_s & ~cnt_full_s) ? 1'b1 : short_q;
        rd_full_d  = rd_take_s ? 1'b0 : rd_fire_s ? 1'b1 : rd_full_q;
        rd_hold_d  = rd_fire_s ? bus.rd_data : rd_hold_q;
    end

    // State and output registers; tdo follows the next shift-register LSB so it is valid from the capture edge.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            rd_hold_q  <= '0;
            rd_full_q  <= 1'b0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            short_q    <= 1'b0;
            ir_out_q   <= 1'b0;
            tdo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            rd_hold_q  <= rd_hold_d;
            rd_full_q  <= rd_full_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            ovf_q      <= ovf_d;
            short_q    <= short_d;
            ir_out_q   <= rd_full_q;
            tdo_q      <= (state_d != IDLE) ? sr_d[0] : 1'b0;
        end
    end

    assign tdo          = tdo_q;
    assign ir_out       = ir_out_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.rd_ready = rd_ready_s;
endmodule

// File: tb/tb_vjtag_dr_ctrl.sv
// Randomized bench for vjtag_dr_ctrl: scans are modelled as whole transactions
// and every user-side output and every shifted tdo bit is checked against the model.
module tb_vjtag_dr_ctrl;
    localparam int DW = 32;

    logic tck = 1'b0;
    logic rst = 1'b1;
    logic tdi = 1'b0, ir_in = 1'b0;
    logic cdr = 1'b0, sdr = 1'b0, udr = 1'b0, cir = 1'b0, uir = 1'b0;
    logic tdo, ir_out;

    vjtag_dr_ctrl_if #(.DW(DW)) bus ();

    vjtag_dr_ctrl #(.DW(DW)) dut (
        .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir), .bus(bus)
    );

    always #5 tck = ~tck;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // behavioural model of the user-visible state
    logic          m_wr_valid, m_rd_full, m_ovf, m_short, m_ir_out;
    logic [DW-1:0] m_wr_data, m_rd_hold;
    // scan-level events scheduled for the next edge
    logic          ev_cdr_wr, ev_udr_wr, ev_ok, ev_consume;
    logic [DW-1:0] ev_word;
    int            wr_rdy_mode, rd_vld_mode;
    logic          rd_fixed;
    logic [DW-1:0] rd_word;

    task automatic model_reset();
        m_wr_valid = 1'b0; m_rd_full = 1'b0; m_ovf = 1'b0; m_short = 1'b0;
        m_ir_out = 1'b0; m_wr_data = '0; m_rd_hold = '0;
        ev_cdr_wr = 1'b0; ev_udr_wr = 1'b0; ev_ok = 1'b0; ev_consume = 1'b0; ev_word = '0;
    endtask

    task automatic model_edge();
        logic full0;
        full0    = m_rd_full;
        m_ir_out = full0;
        if (m_wr_valid && bus.wr_ready) m_wr_valid = 1'b0;
        if (ev_cdr_wr) begin
            m_ovf = 1'b0;
            m_short = 1'b0;
        end
        if (ev_udr_wr) begin
            if (!ev_ok) m_short = 1'b1;
            else if (m_wr_valid) m_ovf = 1'b1;
            else begin
                m_wr_data  = ev_word;
                m_wr_valid = 1'b1;
            end
        end
        if (ev_consume && full0) m_rd_full = 1'b0;
        if (bus.rd_valid && !full0) begin
            m_rd_full = 1'b1;
            m_rd_hold = bus.rd_data;
        end
    endtask

    task automatic tick();
        bus.wr_ready = (wr_rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (wr_rdy_mode == 1);
        bus.rd_valid = (rd_vld_mode == 2) ? 1'($urandom_range(0, 1)) : (rd_vld_mode == 1);
        bus.rd_data  = rd_fixed ? rd_word : DW'($urandom);
        @(posedge tck);
        model_edge();
        #1;
        check_eq("wr_valid", bus.wr_valid, m_wr_valid);
        check_eq("wr_data", bus.wr_data, m_wr_data);
        check_eq("rd_ready", bus.rd_ready, !m_rd_full);
        check_eq("ir_out", ir_out, m_ir_out);
        cdr = 1'b0; sdr = 1'b0; udr = 1'b0; cir = 1'b0; uir = 1'b0;
        ev_cdr_wr = 1'b0; ev_udr_wr = 1'b0; ev_consume = 1'b0;
    endtask

    // end_kind: 0 = UDR, 1 = IR-scan abort, 2 = leave the scan open
    task automatic scan(input bit wr, input int n, input logic [DW-1:0] word, input bit use_word,
                        input int end_kind, output logic [DW-1:0] got);
        logic [DW-1:0] cap;
        bit            bits[$];
        logic          exp_b, b;
        cap = wr ? DW'({m_rd_full, m_short, m_ovf, m_wr_valid})
                 : (m_rd_full ? m_rd_hold : '0);
        got = '0;
        ir_in = wr; cdr = 1'b1; ev_cdr_wr = wr;
        tick();
        for (int k = 0; k <= n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                cdr = 1'($urandom_range(0, 1));
                tdi = 1'($urandom_range(0, 1));
                tick();
            end
            exp_b = (k < DW) ? cap[k] : bits[k - DW];
            check_eq("tdo_shift", tdo, exp_b);
            if (k < DW) got[k] = tdo;
            if (k < n) begin
                b = (use_word && k < DW) ? word[k] : 1'($urandom_range(0, 1));
                bits.push_back(b);
                tdi = b; sdr = 1'b1;
                tick();
            end
        end
        if (end_kind == 0) begin
            if (wr) begin
                ev_udr_wr = 1'b1;
                ev_ok     = (n == DW);
                for (int j = 0; j < DW; j++) ev_word[j] = (j < n) ? bits[j] : 1'b0;
            end else begin
                ev_consume = (n >= DW);
            end
            udr = 1'b1;
            tick();
            check_eq("tdo_idle", tdo, 1'b0);
        end else if (end_kind == 1) begin
            if ($urandom_range(0, 1) == 1) cir = 1'b1; else uir = 1'b1;
            tick();
            check_eq("tdo_abort", tdo, 1'b0);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_tdo", tdo, 1'b0);
        check_eq("rst_ir_out", ir_out, 1'b0);
        check_eq("rst_wr_valid", bus.wr_valid, 1'b0);
        check_eq("rst_wr_data", bus.wr_data, '0);
        check_eq("rst_rd_ready", bus.rd_ready, 1'b0);
        model_reset();
        bus.rd_valid = 1'b1;
        @(posedge tck);
        #1;
        check_eq("rst_hold_rd_ready", bus.rd_ready, 1'b0);
        check_eq("rst_hold_wr_valid", bus.wr_valid, 1'b0);
        bus.rd_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] got;
        wr_rdy_mode = 0; rd_vld_mode = 0; rd_fixed = 1'b0; rd_word = '0;
        bus.wr_ready = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = '0;
        model_reset();
        rst = 1'b1;
        @(posedge tck);
        #1;
        check_eq("init_tdo", tdo, 1'b0);
        check_eq("init_ir_out", ir_out, 1'b0);
        check_eq("init_wr_valid", bus.wr_valid, 1'b0);
        check_eq("init_wr_data", bus.wr_data, '0);
        check_eq("init_rd_ready", bus.rd_ready, 1'b0);
        rst = 1'b0;
        tick();

        // single write with ready high: one-cycle pulse
        wr_rdy_mode = 1;
        scan(1'b1, DW, 32'hA5A5_1234, 1'b1, 0, got);
        check_eq("wr_pulse_valid", bus.wr_valid, 1'b1);
        check_eq("wr_pulse_data", bus.wr_data, 32'hA5A5_1234);
        tick();
        check_eq("wr_pulse_end", bus.wr_valid, 1'b0);

        // overrun: second word dropped, status reports valid+ovf then valid
        wr_rdy_mode = 0;
        scan(1'b1, DW, 32'h1, 1'b1, 0, got);
        scan(1'b1, DW, 32'h2, 1'b1, 0, got);
        check_eq("ovf_keep_data", bus.wr_data, 32'h1);
        scan(1'b1, 8, 32'h0, 1'b1, 1, got);
        check_eq("status_ovf", got, 32'h3);
        scan(1'b1, 8, 32'h0, 1'b1, 1, got);
        check_eq("status_after_clr", got, 32'h1);
        wr_rdy_mode = 1;
        tick();
        tick();

        // short write
        scan(1'b1, DW - 1, 32'h7777_7777, 1'b1, 0, got);
        check_eq("short_no_valid", bus.wr_valid, 1'b0);
        scan(1'b1, 8, 32'h0, 1'b1, 1, got);
        check_eq("status_short", got, 32'h4);

        // read buffer fill, IR capture, full read consumes
        rd_fixed = 1'b1; rd_word = 32'hDEAD_BEEF;
        rd_vld_mode = 1;
        tick();
        rd_vld_mode = 0;
        check_eq("rd_ready_fall", bus.rd_ready, 1'b0);
        cir = 1'b1;
        tick();
        check_eq("ir_out_avail", ir_out, 1'b1);
        scan(1'b0, DW, 32'h0, 1'b0, 0, got);
        check_eq("rd_word", got, 32'hDEAD_BEEF);
        check_eq("rd_consumed", bus.rd_ready, 1'b1);

        // short read keeps the word for a retry
        rd_vld_mode = 1;
        tick();
        rd_vld_mode = 0;
        scan(1'b0, 16, 32'h0, 1'b0, 0, got);
        check_eq("rd_short_kept", bus.rd_ready, 1'b0);
        scan(1'b0, DW, 32'h0, 1'b0, 0, got);
        check_eq("rd_retry_word", got, 32'hDEAD_BEEF);
        rd_fixed = 1'b0;

        // reset in the middle of a write shift
        scan(1'b1, 10, 32'hFFFF_FFFF, 1'b1, 2, got);
        do_reset();
        wr_rdy_mode = 1;
        scan(1'b1, DW, 32'h1234_5678, 1'b1, 0, got);
        check_eq("post_rst_valid", bus.wr_valid, 1'b1);
        check_eq("post_rst_data", bus.wr_data, 32'h1234_5678);

        // randomized scans with random user handshakes and stray strobes
        wr_rdy_mode = 2; rd_vld_mode = 2;
        for (int s = 0; s < 60; s++) begin
            int n, sel, gap;
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1:    n = DW;
                2:       n = DW - 1;
                3:       n = DW + 1;
                4:       n = DW + 2;
                default: n = $urandom_range(1, DW + 3);
            endcase
            scan(1'($urandom_range(0, 1)), n, '0, 1'b0, ($urandom_range(0, 4) == 0) ? 1 : 0, got);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                ir_in = 1'($urandom_range(0, 1));
                tdi   = 1'($urandom_range(0, 1));
                sdr   = 1'($urandom_range(0, 1));
                udr   = 1'($urandom_range(0, 1));
                tick();
                check_eq("tdo_gap", tdo, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
